dcache_axi_bridge: RTL and testbench
====================================

Name: dcache_axi_bridge

Overview:
- Sits directly downstream of the data cache and converts its memory-side strobe/ready port into single-beat AXI4 read and write transactions.
- Serves cached refills, dirty write-backs and uncached pass-through accesses.
- One request is in flight at a time; the request is registered at acceptance and completion is signalled by a one-cycle ready pulse.

Parameters:
- A_WIDTH, 32, address width on both sides.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 1, constant value driven on arid/awid.

Ports:
- clk  in  1  clock
- clrn  in  1  reset, asynchronous, active-low
- c_a  in  A_WIDTH  request address (byte address)
- c_din  in  32  write data from cache
- c_dout  out  32  read data to cache; valid while c_ready=1
- c_strobe  in  1  request valid; held high until c_ready
- c_wen  in  4  byte enables; bit3 = [31:24]
- c_size  in  2  0=byte, 1=half, 2=word
- c_rw  in  1  1=write, 0=read
- c_ready  out  1  one-cycle completion pulse
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_WIDTH/A_WIDTH/8/3/2/1  AXI read address
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/32/2/1/1  AXI read data
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_WIDTH/A_WIDTH/8/3/2/1  AXI write address
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data
- wready  in  1
- bid/bresp/bvalid  in  ID_WIDTH/2/1  AXI write response
- bready  out  1

Behaviour:
- Reset (clrn low, asynchronous): state=IDLE; every valid/ready output=0; c_dout=0; latched request registers=0.
- Constants: len=0, burst=INCR(01), wlast=1, ids=AXI_ID. size={1'b0,c_size}. wstrb=latched c_wen.
- States:
  - IDLE: when c_strobe=1, latch addr/data/wen/size/rw. rw=0 -> RD_ADDR with arvalid=1 next cycle. rw=1 -> WR_ADDR with awvalid=1 and wvalid=1 next cycle.
  - RD_ADDR: hold arvalid and araddr stable until arready; on handshake drop arvalid -> RD_DATA.
  - RD_DATA: rready=1. On rvalid, register rdata into c_dout and pulse c_ready next cycle -> DONE. rresp is ignored for data; the data is always returned.
  - WR_ADDR: AW and W are independent. Sticky flags aw_done and w_done are set on each handshake, and each valid drops after its own handshake. Both handshakes in the same cycle are legal. W may complete before AW. When both are done -> WR_RESP.
  - WR_RESP: bready=1; on bvalid -> DONE with c_ready pulse.
  - DONE: c_ready=1 for exactly this cycle -> IDLE. c_strobe is not sampled in DONE; the cache's still-high strobe is re-evaluated in IDLE on the next cycle, with new address/rw if the cache changed them.
- Latency, zero-wait-state slave: read = 4 cycles from strobe sample to c_ready; write = 4 cycles.
- Inputs c_* may change after acceptance without effect.
- rready/bready are never high outside RD_DATA/WR_RESP. rvalid/bvalid arriving elsewhere is not accepted.
- Reset mid-transaction abandons it; the interconnect is reset by the same clrn.

Optional Feature:
- Macro: DCACHE_AXI_ERR_EN.
- Defined: adds outputs bus_err (1) and err_addr (A_WIDTH). When the DONE state is entered with rresp or bresp != OKAY, bus_err pulses high for that cycle and err_addr latches the request address. err_addr holds until the next error; reset value 0.
- Undefined: ports absent; responses not inspected.

Decomposition:
- Package dcache_axi_pkg: state enum (IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE); AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR; AXI_BURST_INCR; AXI_LEN_SINGLE.
- One natural sub-module: axi_aw_w_join, holding the AW/W sticky-flag logic and asserting both_done.

Test Plan:
- Read, zero-wait slave: c_a=0x0001_0040, rw=0, rdata=0xDEADBEEF -> araddr=0x00010040, arsize=2; c_ready pulses once with c_dout=0xDEADBEEF, 4 cycles after strobe.
- Write, AW delayed: awready after 3 cycles, wready immediate; c_din=0x12345678, wen=4'b1111 -> wvalid drops after 1 cycle, awvalid after 3; c_ready only after bvalid.
- Write, AW/W same cycle: sb with wen=4'b0100, size=0 -> wstrb=0100, awsize=0; single c_ready pulse.
- Write-back then refill: strobe held, rw 1->0 and address changed after the first c_ready -> two distinct AXI transactions in order, no duplicate transaction.
- Reset mid-read: clrn low while in RD_DATA -> outputs 0 immediately; after release, a new read completes normally.
- Error (DCACHE_AXI_ERR_EN defined): rresp=SLVERR on c_a=0x1FC0_0008 -> bus_err pulses with c_ready; err_addr=0x1FC00008.

Source files
------------

// File: rtl/dcache_axi_bridge_pkg.sv
// Shared types and AXI constants for the data-cache to AXI4 bridge.
// Holds the FSM state encoding, AXI response/burst codes and the size mapping.
package dcache_axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    // Cache size code (0=byte,1=half,2=word) maps directly onto AXI log2 size.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/dcache_axi_bridge_aw_w_join.sv
// Joins the independent AW and W channels of a single-beat write: each valid drops on its
// own handshake, sticky flags remember completion, o_both_done fires in the cycle the last one lands.
module axi_aw_w_join (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_awready,
    input  logic i_wready,
    output logic o_awvalid,
    output logic o_wvalid,
    output logic o_both_done
);

    logic r_awvalid;
    logic r_wvalid;
    logic r_aw_done;
    logic r_w_done;
    logic w_aw_hs;
    logic w_w_hs;

    assign w_aw_hs     = r_awvalid & i_awready;
    assign w_w_hs      = r_wvalid & i_wready;
    // Counts a handshake in its own cycle so same-cycle AW+W completes without an extra wait.
    assign o_both_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (i_start) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs)  r_wvalid  <= 1'b0;
            if (o_both_done) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
        end
    end

    assign o_awvalid = r_awvalid;
    assign o_wvalid  = r_wvalid;

endmodule

// File: rtl/dcache_axi_bridge.sv
// Converts the data cache strobe/ready port into single-beat AXI4 reads/writes, one in flight,
// c_ready pulses in the 4th cycle with a zero-wait slave. DCACHE_AXI_ERR_EN adds bus_err/err_addr.
module dcache_axi_bridge
    import dcache_axi_pkg::*;
#(
    parameter int A_WIDTH  = 32,
    parameter int ID_WIDTH = 4,
    parameter int AXI_ID   = 1
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [A_WIDTH-1:0]  c_a,
    input  logic [31:0]         c_din,
    output logic [31:0]         c_dout,
    input  logic                c_strobe,
    input  logic [3:0]          c_wen,
    input  logic [1:0]          c_size,
    input  logic                c_rw,
    output logic                c_ready,
    output logic [ID_WIDTH-1:0] arid,
    output logic [A_WIDTH-1:0]  araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_WIDTH-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [ID_WIDTH-1:0] awid,
    output logic [A_WIDTH-1:0]  awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_WIDTH-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
`ifdef DCACHE_AXI_ERR_EN
    ,
    output logic                bus_err,
    output logic [A_WIDTH-1:0]  err_addr
`endif
);

    localparam logic [ID_WIDTH-1:0] W_ID = ID_WIDTH'(AXI_ID);

    state_t               r_state;
    logic [A_WIDTH-1:0]   r_addr;
    logic [31:0]          r_din;
    logic [3:0]           r_wen;
    logic [1:0]           r_size;
    logic [31:0]          r_dout;
    logic                 r_c_ready;
    logic                 r_arvalid;
    logic                 r_rready;
    logic                 r_bready;
    logic                 w_start_wr;
    logic                 w_both_done;
    logic                 w_unused_sink;
`ifdef DCACHE_AXI_ERR_EN
    logic                 r_bus_err;
    logic [A_WIDTH-1:0]   r_err_addr;
`endif

    assign w_start_wr    = (r_state == IDLE) & c_strobe & c_rw;
    assign w_unused_sink = ^{rid, rlast, bid, rresp, bresp};

    axi_aw_w_join u_aw_w_join (
        .i_clk       (clk),
        .i_rst_n     (clrn),
        .i_start     (w_start_wr),
        .i_awready   (awready),
        .i_wready    (wready),
        .o_awvalid   (awvalid),
        .o_wvalid    (wvalid),
        .o_both_done (w_both_done)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_din     <= '0;
            r_wen     <= '0;
            r_size    <= '0;
            r_dout    <= '0;
            r_c_ready <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_bready  <= 1'b0;
`ifdef DCACHE_AXI_ERR_EN
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (c_strobe) begin
                        r_addr <= c_a;
                        r_din  <= c_din;
                        r_wen  <= c_wen;
                        r_size <= c_size;
                        if (c_rw) begin
                            r_state <= WR_ADDR;
                        end else begin
                            r_state   <= RD_ADDR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        r_rready  <= 1'b0;
                        r_dout    <= rdata;
                        r_c_ready <= 1'b1;
                        r_state   <= DONE;
`ifdef DCACHE_AXI_ERR_EN
                        r_bus_err <= (rresp != AXI_RESP_OKAY);
                        if (rresp != AXI_RESP_OKAY) r_err_addr <= r_addr;
`endif
                    end
                end
                WR_ADDR: begin
                    if (w_both_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        r_bready  <= 1'b0;
                        r_c_ready <= 1'b1;
                        r_state   <= DONE;
`ifdef DCACHE_AXI_ERR_EN
                        r_bus_err <= (bresp != AXI_RESP_OKAY);
                        if (bresp != AXI_RESP_OKAY) r_err_addr <= r_addr;
`endif
                    end
                end
                DONE: begin
                    // Strobe is ignored here; a held strobe is re-sampled in IDLE next cycle.
                    r_c_ready <= 1'b0;
                    r_state   <= IDLE;
`ifdef DCACHE_AXI_ERR_EN
                    r_bus_err <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign c_dout  = r_dout;
    assign c_ready = r_c_ready;

    assign arid    = W_ID;
    assign araddr  = r_addr;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = axi_size(r_size);
    assign arburst = AXI_BURST_INCR;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;

    assign awid    = W_ID;
    assign awaddr  = r_addr;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = axi_size(r_size);
    assign awburst = AXI_BURST_INCR;
    assign wdata   = r_din;
    assign wstrb   = r_wen;
    assign wlast   = 1'b1;
    assign bready  = r_bready;

`ifdef DCACHE_AXI_ERR_EN
    assign bus_err  = r_bus_err;
    assign err_addr = r_err_addr;
`endif

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: inputs change and outputs are sampled 1ns after each rising edge.
module tb_dcache_axi_bridge;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] c_a, c_din, c_dout;
    logic        c_strobe, c_rw, c_ready;
    logic [3:0]  c_wen;
    logic [1:0]  c_size;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;
`ifdef DCACHE_AXI_ERR_EN
    logic        bus_err;
    logic [31:0] err_addr;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dcache_axi_bridge #(.A_WIDTH(32), .ID_WIDTH(4), .AXI_ID(1)) dut (
        .clk(clk), .clrn(clrn),
        .c_a(c_a), .c_din(c_din), .c_dout(c_dout), .c_strobe(c_strobe),
        .c_wen(c_wen), .c_size(c_size), .c_rw(c_rw), .c_ready(c_ready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef DCACHE_AXI_ERR_EN
        , .bus_err(bus_err), .err_addr(err_addr)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clrn = 1'b0;
        c_a = '0; c_din = '0; c_strobe = 1'b0; c_wen = '0; c_size = '0; c_rw = 1'b0;
        arready = 1'b0; rid = 4'd1; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'b00; bvalid = 1'b0;

        #1;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_c_ready", c_ready, 1'b0);
        chk("rst_c_dout", c_dout, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        tick(); tick();
        clrn = 1'b1;
        tick();

        // Read, zero-wait slave: accepted at edge 0, c_ready visible after edge 2 (4th cycle).
        c_strobe = 1'b1; c_rw = 1'b0; c_a = 32'h0001_0040; c_size = 2'd2; c_wen = 4'hF;
        arready = 1'b1;
        tick();
        chk("rd_arvalid", arvalid, 1'b1);
        chk("rd_araddr", araddr, 32'h0001_0040);
        chk("rd_arsize", arsize, 3'd2);
        chk("rd_arlen", arlen, 8'd0);
        chk("rd_arburst", arburst, 2'b01);
        chk("rd_arid", arid, 4'd1);
        chk("rd_rready_early", rready, 1'b0);
        c_a = 32'hFFFF_FFFF;
        tick();
        chk("rd_arvalid_drop", arvalid, 1'b0);
        chk("rd_araddr_latched", araddr, 32'h0001_0040);
        chk("rd_rready", rready, 1'b1);
        chk("rd_c_ready_early", c_ready, 1'b0);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        chk("rd_c_ready", c_ready, 1'b1);
        chk("rd_c_dout", c_dout, 32'hDEAD_BEEF);
        chk("rd_rready_drop", rready, 1'b0);
`ifdef DCACHE_AXI_ERR_EN
        chk("rd_bus_err_ok", bus_err, 1'b0);
`endif
        rvalid = 1'b0; c_strobe = 1'b0; arready = 1'b0;
        tick();
        chk("rd_c_ready_pulse", c_ready, 1'b0);
        chk("rd_c_dout_hold", c_dout, 32'hDEAD_BEEF);
        tick();
        chk("rd_no_new_ar", arvalid, 1'b0);

        // Write with AW delayed: W completes at edge 1, AW at edge 3, response one cycle later.
        c_strobe = 1'b1; c_rw = 1'b1; c_a = 32'h0000_2000; c_din = 32'h1234_5678;
        c_wen = 4'b1111; c_size = 2'd2; awready = 1'b0; wready = 1'b1;
        tick();
        chk("wr1_awvalid", awvalid, 1'b1);
        chk("wr1_wvalid", wvalid, 1'b1);
        chk("wr1_wdata", wdata, 32'h1234_5678);
        chk("wr1_wstrb", wstrb, 4'b1111);
        chk("wr1_wlast", wlast, 1'b1);
        chk("wr1_awaddr", awaddr, 32'h0000_2000);
        chk("wr1_awsize", awsize, 3'd2);
        c_din = 32'h0;
        tick();
        chk("wr1_wvalid_drop", wvalid, 1'b0);
        chk("wr1_awvalid_held", awvalid, 1'b1);
        chk("wr1_wdata_latched", wdata, 32'h1234_5678);
        tick();
        chk("wr1_awvalid_held2", awvalid, 1'b1);
        chk("wr1_bready_early", bready, 1'b0);
        awready = 1'b1;
        tick();
        chk("wr1_awvalid_drop", awvalid, 1'b0);
        chk("wr1_bready", bready, 1'b1);
        chk("wr1_c_ready_early", c_ready, 1'b0);
        awready = 1'b0;
        tick();
        chk("wr1_wait_bvalid", c_ready, 1'b0);
        bvalid = 1'b1;
        tick();
        chk("wr1_c_ready", c_ready, 1'b1);
        chk("wr1_bready_drop", bready, 1'b0);
        bvalid = 1'b0; c_strobe = 1'b0;
        tick();
        chk("wr1_c_ready_pulse", c_ready, 1'b0);

        // Store byte, AW and W handshake in the same cycle.
        c_strobe = 1'b1; c_rw = 1'b1; c_a = 32'h0000_3003; c_din = 32'h00AB_0000;
        c_wen = 4'b0100; c_size = 2'd0; awready = 1'b1; wready = 1'b1;
        tick();
        chk("sb_wstrb", wstrb, 4'b0100);
        chk("sb_awsize", awsize, 3'd0);
        chk("sb_valids", {awvalid, wvalid}, 2'b11);
        tick();
        chk("sb_valids_drop", {awvalid, wvalid}, 2'b00);
        chk("sb_bready", bready, 1'b1);
        bvalid = 1'b1;
        tick();
        chk("sb_c_ready", c_ready, 1'b1);
        bvalid = 1'b0; c_strobe = 1'b0;
        tick();
        chk("sb_c_ready_pulse", c_ready, 1'b0);
        tick();
        chk("sb_no_extra", {c_ready, awvalid, wvalid}, 3'b000);

        // Write-back then refill with the strobe held across c_ready.
        c_strobe = 1'b1; c_rw = 1'b1; c_a = 32'h0000_4000; c_din = 32'h5555_AAAA;
        c_wen = 4'hF; c_size = 2'd2;
        tick();
        chk("wb_awaddr", awaddr, 32'h0000_4000);
        chk("wb_awvalid", awvalid, 1'b1);
        tick();
        bvalid = 1'b1;
        tick();
        chk("wb_c_ready", c_ready, 1'b1);
        bvalid = 1'b0; c_rw = 1'b0; c_a = 32'h0000_5000; arready = 1'b1;
        tick();
        chk("wb_done_no_dup", {c_ready, arvalid, awvalid, wvalid}, 4'b0000);
        tick();
        chk("rf_arvalid", arvalid, 1'b1);
        chk("rf_araddr", araddr, 32'h0000_5000);
        chk("rf_no_aw", awvalid, 1'b0);
        tick();
        chk("rf_rready", rready, 1'b1);
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        tick();
        chk("rf_c_ready", c_ready, 1'b1);
        chk("rf_c_dout", c_dout, 32'hCAFE_F00D);
        rvalid = 1'b0; c_strobe = 1'b0;
        tick();
        chk("rf_idle", {c_ready, arvalid, rready}, 3'b000);

        // Reset asserted while in RD_DATA.
        c_strobe = 1'b1; c_rw = 1'b0; c_a = 32'h0000_6000;
        tick();
        tick();
        chk("mr_rready", rready, 1'b1);
        clrn = 1'b0;
        #2;
        chk("mr_rready_rst", rready, 1'b0);
        chk("mr_arvalid_rst", arvalid, 1'b0);
        chk("mr_c_dout_rst", c_dout, 32'h0);
        chk("mr_c_ready_rst", c_ready, 1'b0);
        c_strobe = 1'b0;
        tick();
        clrn = 1'b1;
        tick();
        c_strobe = 1'b1; c_a = 32'h0000_7000;
        tick();
        chk("mr2_araddr", araddr, 32'h0000_7000);
        tick();
        rvalid = 1'b1; rdata = 32'h0BAD_F00D;
        tick();
        chk("mr2_c_ready", c_ready, 1'b1);
        chk("mr2_c_dout", c_dout, 32'h0BAD_F00D);
        rvalid = 1'b0; c_strobe = 1'b0;
        tick();

`ifdef DCACHE_AXI_ERR_EN
        // Read returning SLVERR.
        chk("err_rst_addr", err_addr, 32'h0);
        c_strobe = 1'b1; c_rw = 1'b0; c_a = 32'h1FC0_0008;
        tick();
        tick();
        rvalid = 1'b1; rdata = 32'h1111_2222; rresp = 2'b10;
        tick();
        chk("err_c_ready", c_ready, 1'b1);
        chk("err_bus_err", bus_err, 1'b1);
        chk("err_addr", err_addr, 32'h1FC0_0008);
        chk("err_data_returned", c_dout, 32'h1111_2222);
        rvalid = 1'b0; rresp = 2'b00; c_strobe = 1'b0;
        tick();
        chk("err_bus_err_pulse", bus_err, 1'b0);
        chk("err_addr_hold", err_addr, 32'h1FC0_0008);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
